// File: rtl/hex_scan_driver.sv
// Time-multiplexed N-digit hex driver for common-anode 7-segment banks on shared segment lines.
// Latency: seg/dig_en registered, one edge after the div_cnt/idx/value_q/blink_ph state they reflect.
// Backpressure: none; free-running scan, load captures value on any edge.
module hex_scan_driver #(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 50000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [DW-1:0]           div_cnt;
    logic [IW-1:0]           idx;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_ph;

    logic [3:0]              cur_nib;
    logic                    cur_blink;
    logic                    cur_upper_zero;
    logic                    guard;
    logic                    blank;
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   den_n;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Leading-zero test: the current digit and every more-significant nibble must be zero.
    always_comb begin
        cur_nib        = 4'h0;
        cur_blink      = 1'b0;
        cur_upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j == int'(idx)) begin
                cur_nib   = value_q[4*j +: 4];
                cur_blink = blink_mask[j];
            end
            if (j >= int'(idx) && value_q[4*j +: 4] != 4'h0) begin
                cur_upper_zero = 1'b0;
            end
        end
    end

    always_comb begin
        guard = (div_cnt == '0);
        blank = (lz_blank && cur_upper_zero && (idx != '0)) || (cur_blink && blink_ph);
        seg_n = (guard || blank) ? 7'h7F : glyph(cur_nib);
        den_n = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (!guard && j == int'(idx)) begin
                den_n[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value_q   <= '0;
            div_cnt   <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            seg       <= 7'h7F;
            dig_en    <= '1;
        end else begin
            if (load) begin
                value_q <= value;
            end
            if (div_cnt == DW'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                idx     <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            seg    <= seg_n;
            dig_en <= den_n;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with 4 digits, 4-cycle slots and 16-cycle blink half-period.
module tb_hex_scan_driver;
    logic        clock;
    logic        resetn;
    logic [15:0] value;
    logic        load;
    logic        lz_blank;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  dig_en;

    int n_assert;
    int n_fail;

    logic [6:0]  glyphs [16];
    logic [63:0] den_tab;
    logic [7:0]  ld_seg [16];

    hex_scan_driver #(
        .NUM_DIGITS(4),
        .CLK_DIV   (4),
        .BLINK_DIV (16)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .value     (value),
        .load      (load),
        .lz_blank  (lz_blank),
        .blink_mask(blink_mask),
        .seg       (seg),
        .dig_en    (dig_en)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Starts on a frame boundary: loads v on the guard edge, then checks all 16 cycles.
    task automatic frame_check(input string tag, input logic [15:0] v, input logic lz,
                               input logic [3:0] m, input logic [31:0] exp_segs);
        value      = v;
        lz_blank   = lz;
        blink_mask = m;
        load       = 1'b1;
        for (int p = 0; p < 16; p++) begin
            step();
            load = 1'b0;
            chk($sformatf("%s p%0d dig_en", tag, p), {4'h0, dig_en}, {4'h0, den_tab[4*p +: 4]});
            chk($sformatf("%s p%0d seg", tag, p), {1'b0, seg},
                (p % 4 == 0) ? 8'h7F : exp_segs[8*(p/4) +: 8]);
        end
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        glyphs     = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        den_tab    = 64'h777F_BBBF_DDDF_EEEF;
        ld_seg     = '{8'h7F, 8'h79, 8'h79, 8'h00, 8'h7F, 8'h12, 8'h12, 8'h12,
                       8'h7F, 8'h24, 8'h24, 8'h24, 8'h7F, 8'h79, 8'h79, 8'h79};
        resetn     = 1'b0;
        value      = 16'h0;
        load       = 1'b0;
        lz_blank   = 1'b0;
        blink_mask = 4'h0;

        step();
        step();
        chk("reset seg", {1'b0, seg}, 8'h7F);
        chk("reset dig_en", {4'h0, dig_en}, 8'h0F);

        resetn = 1'b1;
        frame_check("scan0", 16'h1234, 1'b0, 4'h0, {8'h79, 8'h24, 8'h30, 8'h19});
        frame_check("scan1", 16'h1234, 1'b0, 4'h0, {8'h79, 8'h24, 8'h30, 8'h19});

        for (int g = 0; g < 16; g++) begin
            frame_check($sformatf("glyph%0h", g), {12'h000, 4'(g)}, 1'b0, 4'h0,
                        {8'h40, 8'h40, 8'h40, {1'b0, glyphs[g]}});
        end

        frame_check("lz0040", 16'h0040, 1'b1, 4'h0, {8'h7F, 8'h7F, 8'h19, 8'h40});
        frame_check("lz0000", 16'h0000, 1'b1, 4'h0, {8'h7F, 8'h7F, 8'h7F, 8'h40});
        frame_check("nolz0040", 16'h0040, 1'b0, 4'h0, {8'h40, 8'h40, 8'h19, 8'h40});
        frame_check("lz1030", 16'h1030, 1'b1, 4'h0, {8'h79, 8'h40, 8'h30, 8'h40});

        // Mid-slot load (1->8 on digit 0), then a load coinciding with the slot wrap.
        frame_check("preload", 16'h1231, 1'b0, 4'h0, {8'h79, 8'h24, 8'h30, 8'h79});
        for (int p = 0; p < 16; p++) begin
            step();
            chk($sformatf("ld p%0d dig_en", p), {4'h0, dig_en}, {4'h0, den_tab[4*p +: 4]});
            chk($sformatf("ld p%0d seg", p), {1'b0, seg}, ld_seg[p]);
            if (p == 1) begin
                value = 16'h1238;
                load  = 1'b1;
            end else if (p == 2) begin
                value = 16'h1258;
            end else if (p == 3) begin
                load = 1'b0;
            end
        end

        // Asynchronous reset while digit 2 is lit.
        for (int p = 0; p < 10; p++) begin
            step();
        end
        chk("pre-arst seg", {1'b0, seg}, 8'h24);
        chk("pre-arst dig_en", {4'h0, dig_en}, 8'h0B);
        #2 resetn = 1'b0;
        #1;
        chk("arst seg", {1'b0, seg}, 8'h7F);
        chk("arst dig_en", {4'h0, dig_en}, 8'h0F);
        step();
        step();
        resetn = 1'b1;
        frame_check("restart", 16'h1234, 1'b0, 4'h0, {8'h79, 8'h24, 8'h30, 8'h19});

        frame_check("blink_off", 16'h1234, 1'b0, 4'b0010, {8'h79, 8'h24, 8'h7F, 8'h19});
        frame_check("blink_on", 16'h1234, 1'b0, 4'b0010, {8'h79, 8'h24, 8'h30, 8'h19});
        frame_check("blink_off2", 16'h1234, 1'b0, 4'b0010, {8'h79, 8'h24, 8'h7F, 8'h19});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_scan_driver.md
# hex_scan_driver

Parametrised, time-multiplexed hexadecimal display driver for multi-digit common-anode 7-segment banks that share one set of segment lines. It holds an N-digit hex value and scans the digits at a programmable rate. It supports optional leading-zero blanking, per-digit blinking and an anti-ghosting guard cycle. It sits between datapath registers and the board display pins and replaces per-digit combinational decoders where pins are shared.

## Interface
Parameters:
- NUM_DIGITS, 6, number of digits scanned (≥1)
- CLK_DIV, 50000, clock cycles each digit slot lasts (≥2)
- BLINK_DIV, 25000000, clock cycles per blink half-period (≥1)

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- value  in  4*NUM_DIGITS  hex value; nibble i (bits 4i+3:4i) is digit i, digit 0 least significant
- load  in  1  capture value into the internal value register this edge
- lz_blank  in  1  enable leading-zero blanking
- blink_mask  in  NUM_DIGITS  bit i = 1: digit i blinks
- seg  out  7  segments g..a (seg[0]=a … seg[6]=g), active-low
- dig_en  out  NUM_DIGITS  digit enables, active-low, at most one low

## Operation
- Registers: value_q, div_cnt (0..CLK_DIV-1), idx (0..NUM_DIGITS-1), blink_cnt (0..BLINK_DIV-1), blink_ph, seg, dig_en.
- Reset (async, resetn=0): value_q=0, div_cnt=0, idx=0, blink_cnt=0, blink_ph=0, seg=7'h7F, dig_en=all 1.
- Load: value_q <= value on any edge with load=1. Otherwise it holds.
- Scan: div_cnt increments every cycle. At CLK_DIV-1 it wraps to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Blink: blink_cnt increments every cycle. At BLINK_DIV-1 it wraps to 0 and blink_ph toggles. blink_ph=0 means visible.
- Glyphs (active-low, seg[6:0]): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Digit i is blank (seg=7'h7F) if either condition holds:
  - lz_blank=1 and nibbles i..NUM_DIGITS-1 of value_q are all 0 and i≠0. Digit 0 is never LZ-blanked.
  - blink_mask[i]=1 and blink_ph=1.
- Blanking forces seg=7'h7F; the enable still follows the scan.
- Guard: in the slot cycle with div_cnt=0, dig_en=all 1 and seg=7'h7F. Otherwise dig_en[idx]=0 and all other enables are 1.
- blink_mask and lz_blank are used live (not captured by load).

## Timing
- seg/dig_en are registered and computed from the current cycle's div_cnt/idx/value_q/blink_ph. They are visible one edge later.
- Slot pattern per digit: 1 guard cycle, then CLK_DIV-1 cycles lit. Full frame = NUM_DIGITS*CLK_DIV cycles.
- First edge after reset release: outputs show the guard for slot 0. Digit 0 is lit from the 2nd edge onward.
- Load latency: load sampled at edge k puts the new value_q in effect after k. It appears on seg at edge k+1.
- Load and slot wrap on the same edge: both take effect. The new digit shows the new value at the next lit cycle.
- NUM_DIGITS=1: idx stays 0, and the guard still occurs every CLK_DIV cycles.
- Reset mid-frame: outputs go dark immediately (async) and the scan restarts at digit 0.

## Test plan
- Reset/scan: NUM_DIGITS=4, CLK_DIV=4, value=16'h1234 loaded.
  - Required: after reset, seg=7F, dig_en=F. Then a repeating 16-cycle frame.
  - dig_en pattern: F,E,E,E, F,D,D,D, F,B,B,B, F,7,7,7.
  - seg per lit digit: 19 (4), 30 (3), 24 (2), 79 (1).
- Glyphs: load each of 0..F into digit 0 -> seg matches the glyph table (e.g. A->08, d->21, F->0E).
- Leading-zero: value=16'h0040, lz_blank=1 -> digits 3,2 show 7F, digit 1 shows 19, digit 0 shows 40. value=0 -> only digit 0 lit with 40. lz_blank=0 -> digits 3,2 show 40.
- Blink: BLINK_DIV=16, blink_mask=4'b0010 -> digit 1 seg alternates between its glyph and 7F every 16 cycles. Its dig_en still strobes low. Other digits are unaffected.
- Load timing: load pulse mid-slot changing digit 0 from 1 to 8 -> the next lit cycle after the one-edge latency shows 00, with no corruption of other digits.
- Async reset mid-frame in slot 2: seg=7F and dig_en=F without a clock edge. After release, the scan restarts with the slot-0 guard.
